// File: rtl/smuladd_pkg.sv
// smuladd shared definitions: operand width, Booth iteration count,
// FSM state encoding and a 17-bit magnitude helper.
package smuladd_pkg;

    localparam int W          = 16;
    localparam int MUL_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD_D = 3'd1,
        LD_R = 3'd2,
        MUL  = 3'd3,
        ADD  = 3'd4,
        DONE = 3'd5
    } state_e;

    // One extra bit so that |0x8000| = 32768 is representable.
    function automatic logic [W:0] abs17(input logic [W-1:0] x);
        logic [W:0] xs;
        xs = {x[W-1], x};
        return x[W-1] ? -xs : xs;
    endfunction

endpackage

// File: rtl/smuladd_booth_step.sv
// One radix-2 Booth iteration on a 33-bit accumulator.
// Ports: acc_i {A[16:0], multiplier[15:0]}, qm1_i previous multiplier
//        bit, d_i multiplicand; acc_o/qm1_o next accumulator and bit.
module smuladd_booth_step
    import smuladd_pkg::*;
(
    input  logic [2*W:0] acc_i,
    input  logic         qm1_i,
    input  logic [W-1:0] d_i,
    output logic [2*W:0] acc_o,
    output logic         qm1_o
);

    logic [W:0] hi;
    logic [W:0] dx;
    logic [W:0] sum;

    always_comb begin
        hi  = acc_i[2*W:W];
        dx  = {d_i[W-1], d_i};
        sum = hi;
        case ({acc_i[0], qm1_i})
            2'b01:   sum = hi + dx;
            2'b10:   sum = hi - dx;
            default: sum = hi;
        endcase
        // Arithmetic shift right of {sum, multiplier bits}.
        acc_o = {sum[W], sum, acc_i[W-1:1]};
        qm1_o = acc_i[0];
    end

endmodule

// File: rtl/smuladd.sv
// Signed multiply-add: Result = Q*D + R from Q, D, R loaded over Dbus.
// Ports: CLK, Rst (sync high), St, Dbus in; Result, V, Rdy, Busy out.
module smuladd
    import smuladd_pkg::*;
(
    input  logic           CLK,
    input  logic           Rst,
    input  logic           St,
    input  logic [W-1:0]   Dbus,
    output logic [2*W-1:0] Result,
    output logic           V,
    output logic           Rdy,
    output logic           Busy
);

    state_e state_q, state_d;

    logic [4:0]     cnt_q, cnt_d;
    logic [W-1:0]   mq_q, mq_d;
    logic [W-1:0]   md_q, md_d;
    logic [W-1:0]   rm_q, rm_d;
    logic [2*W:0]   acc_q, acc_d;
    logic           qm1_q, qm1_d;
    logic [2*W-1:0] res_q, res_d;
    logic           v_q, v_d;

    logic [2*W:0]   step_acc;
    logic           step_qm1;
    logic           unused_acc_msb;

    smuladd_booth_step u_step (
        .acc_i (acc_q),
        .qm1_i (qm1_q),
        .d_i   (md_q),
        .acc_o (step_acc),
        .qm1_o (step_qm1)
    );

    // The product always fits in 32 bits; bit 32 is only a sign copy.
    assign unused_acc_msb = acc_q[2*W];

    always_ff @(posedge CLK) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // DONE also samples St so back-to-back starts keep a 20-cycle period.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (St) state_d = LD_D;
            LD_D:    state_d = LD_R;
            LD_R:    state_d = MUL;
            MUL:     if (cnt_q == 5'(MUL_CYCLES - 1)) state_d = ADD;
            ADD:     state_d = DONE;
            DONE:    state_d = St ? LD_D : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Rdy  = (state_q == DONE);
        Busy = (state_q != IDLE);
    end

    always_comb begin
        cnt_d = cnt_q;
        mq_d  = mq_q;
        md_d  = md_q;
        rm_d  = rm_q;
        acc_d = acc_q;
        qm1_d = qm1_q;
        res_d = res_q;
        v_d   = v_q;
        unique case (state_q)
            IDLE, DONE: if (St) mq_d = Dbus;
            LD_D:       md_d = Dbus;
            LD_R: begin
                rm_d  = Dbus;
                acc_d = {{(W+1){1'b0}}, mq_q};
                qm1_d = 1'b0;
                cnt_d = 5'd0;
            end
            MUL: begin
                acc_d = step_acc;
                qm1_d = step_qm1;
                cnt_d = cnt_q + 5'd1;
            end
            ADD: begin
                res_d = acc_q[2*W-1:0] + {{W{rm_q[W-1]}}, rm_q};
                v_d   = (abs17(rm_q) >= abs17(md_q));
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            cnt_q <= '0;
            mq_q  <= '0;
            md_q  <= '0;
            rm_q  <= '0;
            acc_q <= '0;
            qm1_q <= 1'b0;
            res_q <= '0;
            v_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mq_q  <= mq_d;
            md_q  <= md_d;
            rm_q  <= rm_d;
            acc_q <= acc_d;
            qm1_q <= qm1_d;
            res_q <= res_d;
            v_q   <= v_d;
        end
    end

    assign Result = res_q;
    assign V      = v_q;

endmodule

// File: tb/tb_smuladd.sv
// Scoreboard bench for smuladd: directed Q/D/R vectors, back-to-back
// starts with St held high, and a mid-multiply reset abort.
module tb_smuladd;

    logic        CLK = 1'b0;
    logic        Rst;
    logic        St;
    logic [15:0] Dbus;
    logic [31:0] Result;
    logic        V;
    logic        Rdy;
    logic        Busy;

    always #5 CLK = ~CLK;

    smuladd dut (
        .CLK    (CLK),
        .Rst    (Rst),
        .St     (St),
        .Dbus   (Dbus),
        .Result (Result),
        .V      (V),
        .Rdy    (Rdy),
        .Busy   (Busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        v;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   n_done = 0;
    int   want   = 0;
    logic prev_rdy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per Rdy pulse.
    always @(negedge CLK) begin
        if (Rdy === 1'b1) begin
            chk("rdy_single", {31'b0, prev_rdy}, 32'd0);
            chk("busy_with_rdy", {31'b0, Busy}, 32'd1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: got Rdy=1 want no pulse");
            end else begin
                me = sb.pop_front();
                chk("result", Result, me.res);
                chk("v", {31'b0, V}, {31'b0, me.v});
                chk("latency", 32'(cyc - me.stamp), 32'd19);
            end
            n_done++;
        end
        prev_rdy = Rdy;
    end

    task automatic start(input logic [15:0] q, input logic [15:0] d,
                         input logic [15:0] r, input logic [31:0] er,
                         input logic ev);
        @(negedge CLK);
        St   = 1'b1;
        Dbus = q;
        @(negedge CLK);
        sb.push_back('{er, ev, cyc});
        chk("busy_after_start", {31'b0, Busy}, 32'd1);
        St   = 1'b0;
        Dbus = d;
        @(negedge CLK);
        Dbus = r;
        @(negedge CLK);
        Dbus = 16'($urandom);
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (n_done < n && t < 40) begin
            @(negedge CLK);
            Dbus = 16'($urandom);
            t++;
        end
        if (n_done < n) begin
            total++;
            bad++;
            $display("FAIL timeout: done=%0d want=%0d", n_done, n);
        end
        @(negedge CLK);
        chk("idle_busy", {31'b0, Busy}, 32'd0);
        chk("idle_rdy", {31'b0, Rdy}, 32'd0);
    endtask

    logic [15:0] vq [7] = '{16'h000F, 16'hBFFE, 16'h7FFF, 16'h8000,
                            16'h0000, 16'h1234, 16'hFFFF};
    logic [15:0] vd [7] = '{16'h0007, 16'hE005, 16'h8000, 16'h8000,
                            16'h0001, 16'h0000, 16'h7FFF};
    logic [15:0] vr [7] = '{16'h0006, 16'h00C5, 16'h0000, 16'h7FFF,
                            16'h0005, 16'h0000, 16'hFFFF};
    logic [31:0] vres [7] = '{32'h0000006F, 32'h07FF00BB, 32'hC0008000,
                              32'h40007FFF, 32'h00000005, 32'h00000000,
                              32'hFFFF8000};
    logic        vv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s1;
        int s2;
        int t;
        Rst  = 1'b1;
        St   = 1'b0;
        Dbus = 16'h0;
        repeat (2) @(negedge CLK);
        chk("rst_result", Result, 32'd0);
        chk("rst_v", {31'b0, V}, 32'd0);
        chk("rst_rdy", {31'b0, Rdy}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        Rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start(vq[i], vd[i], vr[i], vres[i], vv[i]);
            want++;
            wait_done(want);
        end

        // St held high: second Q is taken at the DONE edge of the first.
        @(negedge CLK);
        St   = 1'b1;
        Dbus = 16'h000F;
        @(negedge CLK);
        s1 = cyc;
        sb.push_back('{32'h0000006F, 1'b0, s1});
        Dbus = 16'h0007;
        @(negedge CLK);
        Dbus = 16'h0006;
        t = 0;
        while (cyc != s1 + 19 && t < 40) begin
            @(negedge CLK);
            Dbus = 16'($urandom);
            t++;
        end
        Dbus = 16'h0003;
        @(negedge CLK);
        s2 = cyc;
        sb.push_back('{32'hFFFFFFFB, 1'b0, s2});
        chk("b2b_busy", {31'b0, Busy}, 32'd1);
        Dbus = 16'hFFFE;
        @(negedge CLK);
        Dbus = 16'h0001;
        St   = 1'b0;
        want += 2;
        wait_done(want);

        // Reset sampled at edge 10 of a transaction aborts it.
        @(negedge CLK);
        St   = 1'b1;
        Dbus = 16'h0101;
        @(negedge CLK);
        s1   = cyc;
        St   = 1'b0;
        Dbus = 16'h0202;
        t = 0;
        while (cyc != s1 + 9 && t < 40) begin
            @(negedge CLK);
            Dbus = 16'($urandom);
            t++;
        end
        Rst = 1'b1;
        @(negedge CLK);
        chk("abort_result", Result, 32'd0);
        chk("abort_v", {31'b0, V}, 32'd0);
        chk("abort_rdy", {31'b0, Rdy}, 32'd0);
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        Rst = 1'b0;
        repeat (25) @(negedge CLK);
        chk("abort_no_rdy", 32'(n_done), 32'(want));

        start(16'h0010, 16'hFFF0, 16'hFFF1, 32'hFFFFFEF1, 1'b0);
        want++;
        wait_done(want);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
